// File: rtl/button_cond_pkg.sv
// Shared types and helpers for the push-button conditioner.
package button_cond_pkg;

  typedef enum logic [1:0] {
    RELEASED,
    ARMING,
    HELD,
    DISARMING
  } ch_state_t;

  // Bits needed to hold a counter value of 0..max.
  function automatic int cnt_w(input int max);
    return $clog2(max + 1);
  endfunction

endpackage

// File: rtl/button_conditioner_channel.sv
// One button channel: 2-flop synchroniser, debounce FSM, hold and repeat counters.
// Auto-repeat is built only when BUTTON_COND_REPEAT_EN is defined.
module button_channel
  import button_cond_pkg::*;
#(
  parameter int STABLE_SAMPLES = 8,
  parameter int HOLD_SAMPLES   = 1000,
  parameter int REPEAT_SAMPLES = 200
) (
  input  logic clk_in,
  input  logic rst,
  input  logic tick,
  input  logic pb,
  output logic level,
  output logic press,
  output logic release_pulse,
  output logic long_press,
  output logic repeat_pulse
);

  localparam int CW = cnt_w(STABLE_SAMPLES);
  localparam int HW = cnt_w(HOLD_SAMPLES);
  localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_SAMPLES);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_SAMPLES);

  ch_state_t       state;
  logic            s1;
  logic            s2;
  logic [CW-1:0]   cnt;
  logic [HW-1:0]   hold;
  logic            hold_sat;

  assign hold_sat = (hold == HOLD_MAX);

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state         <= RELEASED;
      s1            <= 1'b0;
      s2            <= 1'b0;
      cnt           <= '0;
      hold          <= '0;
      level         <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
    end else begin
      s1            <= pb;
      s2            <= s1;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
      if (tick) begin
        case (state)
          RELEASED: begin
            if (s2) begin
              state <= ARMING;
              cnt   <= CW'(1);
            end
          end
          ARMING: begin
            if (!s2) begin
              state <= RELEASED;
              cnt   <= '0;
            end else if (cnt + CW'(1) == CNT_MAX) begin
              state      <= HELD;
              cnt        <= '0;
              hold       <= HW'(STABLE_SAMPLES);
              level      <= 1'b1;
              press      <= 1'b1;
              long_press <= (STABLE_SAMPLES == HOLD_SAMPLES);
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          HELD: begin
            if (!s2) begin
              state <= DISARMING;
              cnt   <= CW'(1);
            end else if (!hold_sat) begin
              hold <= hold + HW'(1);
              if (hold + HW'(1) == HOLD_MAX) long_press <= 1'b1;
            end
          end
          DISARMING: begin
            // A bounce back high resumes HELD with the hold count frozen.
            if (s2) begin
              state <= HELD;
              cnt   <= '0;
            end else if (cnt + CW'(1) == CNT_MAX) begin
              state         <= RELEASED;
              cnt           <= '0;
              hold          <= '0;
              level         <= 1'b0;
              release_pulse <= 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          default: state <= RELEASED;
        endcase
      end
    end
  end

`ifdef BUTTON_COND_REPEAT_EN
  localparam int RW = cnt_w(REPEAT_SAMPLES);
  localparam logic [RW-1:0] RPT_MAX = RW'(REPEAT_SAMPLES);

  logic [RW-1:0] rpt_cnt;

  // Only counts saturated HELD ticks, so a bounce pauses it and a release clears it.
  always_ff @(posedge clk_in) begin
    if (rst || state == RELEASED) begin
      rpt_cnt      <= '0;
      repeat_pulse <= 1'b0;
    end else begin
      repeat_pulse <= 1'b0;
      if (tick && state == HELD && s2 && hold_sat) begin
        if (rpt_cnt + RW'(1) == RPT_MAX) begin
          rpt_cnt      <= '0;
          repeat_pulse <= 1'b1;
        end else begin
          rpt_cnt <= rpt_cnt + RW'(1);
        end
      end
    end
  end
`else
  assign repeat_pulse = 1'b0;
`endif

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel push-button conditioner: shared sample prescaler plus N_CH channels.
// Auto-repeat is enabled with BUTTON_COND_REPEAT_EN; release/repeat ports carry a _pulse suffix since both words are keywords.
module button_conditioner
  import button_cond_pkg::*;
#(
  parameter int N_CH           = 4,
  parameter int CLK_HZ         = 100_000_000,
  parameter int SAMPLE_HZ      = 1000,
  parameter int STABLE_SAMPLES = 8,
  parameter int HOLD_SAMPLES   = 1000,
  parameter int REPEAT_SAMPLES = 200
) (
  input  logic            clk_in,
  input  logic            rst,
  input  logic [N_CH-1:0] pb,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] long_press,
  output logic [N_CH-1:0] repeat_pulse
);

  localparam int DIV = CLK_HZ / SAMPLE_HZ;
  localparam int PW  = $clog2(DIV);

  logic [PW-1:0] div_cnt;
  logic          tick;

  assign tick = (div_cnt == PW'(DIV - 1));

  always_ff @(posedge clk_in) begin
    if (rst)       div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + PW'(1);
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    button_channel #(
      .STABLE_SAMPLES(STABLE_SAMPLES),
      .HOLD_SAMPLES  (HOLD_SAMPLES),
      .REPEAT_SAMPLES(REPEAT_SAMPLES)
    ) u_ch (
      .clk_in       (clk_in),
      .rst          (rst),
      .tick         (tick),
      .pb           (pb[i]),
      .level        (level[i]),
      .press        (press[i]),
      .release_pulse(release_pulse[i]),
      .long_press   (long_press[i]),
      .repeat_pulse (repeat_pulse[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboarded bench for button_conditioner; the reference model counts samples per channel
// and queues expected strobes, a negedge monitor pops and compares them.
module tb_button_conditioner;

  localparam int N_CH   = 4;
  localparam int DIV    = 10;
  localparam int STABLE = 4;
  localparam int HOLD   = 20;
  localparam int RPT    = 5;

  logic            clk_in = 1'b0;
  logic            rst = 1'b1;
  logic [N_CH-1:0] pb = '0;
  logic [N_CH-1:0] level, press, release_pulse, long_press, repeat_pulse;

  button_conditioner #(
    .N_CH(N_CH), .CLK_HZ(1000), .SAMPLE_HZ(100),
    .STABLE_SAMPLES(STABLE), .HOLD_SAMPLES(HOLD), .REPEAT_SAMPLES(RPT)
  ) dut (
    .clk_in(clk_in), .rst(rst), .pb(pb), .level(level), .press(press),
    .release_pulse(release_pulse), .long_press(long_press), .repeat_pulse(repeat_pulse)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int              cyc;
    logic [N_CH-1:0] p;
    logic [N_CH-1:0] r;
    logic [N_CH-1:0] l;
    logic [N_CH-1:0] rp;
  } ev_t;

  ev_t exp_q[$];
  ev_t ev;
  ev_t got;
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;

  // Reference model: level flips after STABLE consecutive opposite samples;
  // hold counts agreeing high samples, repeats fire every RPT saturated samples.
  logic [N_CH-1:0] m_s1 = '0, m_s2 = '0, m_smp = '0, m_lvl = '0;
  int              m_div = 0;
  bit              m_tick;
  int              m_opp[N_CH];
  int              m_hold[N_CH];
  int              m_sat[N_CH];

  always @(posedge clk_in) begin
    cyc++;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_div = 0;
      for (int i = 0; i < N_CH; i++) begin
        m_opp[i] = 0; m_hold[i] = 0; m_sat[i] = 0;
      end
    end else begin
      m_smp  = m_s2;
      m_s2   = m_s1;
      m_s1   = pb;
      m_tick = (m_div == DIV - 1);
      m_div  = (m_div + 1) % DIV;
      if (m_tick) begin
        ev.cyc = cyc; ev.p = '0; ev.r = '0; ev.l = '0; ev.rp = '0;
        for (int i = 0; i < N_CH; i++) begin
          if (m_smp[i] != m_lvl[i]) begin
            m_opp[i]++;
            if (m_opp[i] == STABLE) begin
              m_opp[i] = 0;
              m_lvl[i] = m_smp[i];
              if (m_smp[i]) begin
                ev.p[i] = 1'b1; m_hold[i] = STABLE;
              end else begin
                ev.r[i] = 1'b1; m_hold[i] = 0; m_sat[i] = 0;
              end
            end
          end else begin
            if (m_lvl[i] && m_opp[i] == 0) begin
              if (m_hold[i] < HOLD) begin
                m_hold[i]++;
                if (m_hold[i] == HOLD) ev.l[i] = 1'b1;
              end else begin
                m_sat[i]++;
`ifdef BUTTON_COND_REPEAT_EN
                if (m_sat[i] % RPT == 0) ev.rp[i] = 1'b1;
`endif
              end
            end
            m_opp[i] = 0;
          end
        end
        if ((ev.p | ev.r | ev.l | ev.rp) != '0) exp_q.push_back(ev);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, expv, cyc);
    end
  endtask

  // Monitor: level every cycle, strobes whenever the DUT shows any.
  always @(negedge clk_in) begin
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      checks++;
      errors++;
      $display("[TB] FAIL missed_strobe: got none expected p=%0h r=%0h l=%0h rp=%0h at cycle %0d",
               exp_q[0].p, exp_q[0].r, exp_q[0].l, exp_q[0].rp, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    checkOutput("level", level, m_lvl);
    if ((press | release_pulse | long_press | repeat_pulse) != '0) begin
      if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_strobe: got p=%0h r=%0h l=%0h rp=%0h expected none at cycle %0d",
                 press, release_pulse, long_press, repeat_pulse, cyc);
      end else begin
        got = exp_q.pop_front();
        checkOutput("press", press, got.p);
        checkOutput("release", release_pulse, got.r);
        checkOutput("long_press", long_press, got.l);
        checkOutput("repeat", repeat_pulse, got.rp);
      end
    end
  end

  task automatic applyStimulus(input logic [N_CH-1:0] v, input int n);
    pb = v;
    repeat (n) @(negedge clk_in);
  endtask

  // Drives pb for n cycles while counting strobes on one channel.
  task automatic runCount(input logic [N_CH-1:0] v, input int n, input int ch,
                          output int np, output int nr, output int nl, output int nrp,
                          output int nlvl, output int first_p);
    np = 0; nr = 0; nl = 0; nrp = 0; nlvl = 0; first_p = -1;
    pb = v;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk_in);
      if (press[ch]) begin
        np++;
        if (first_p < 0) first_p = k;
      end
      if (release_pulse[ch]) nr++;
      if (long_press[ch]) nl++;
      if (repeat_pulse[ch]) nrp++;
      if (level[ch]) nlvl++;
    end
  endtask

  int np, nr, nl, nrp, nlvl, fp, lat;

  initial begin
    // Reset with all buttons down: nothing may come out, then a fresh press.
    rst = 1'b1;
    pb  = 4'hF;
    repeat (3) begin
      @(negedge clk_in);
      checkOutput("reset_quiet", {level, press, release_pulse, long_press, repeat_pulse}, 32'h0);
    end
    rst = 1'b0;
    lat = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk_in);
      if (press != '0) begin
        lat = k;
        break;
      end
    end
    checkOutput("reset_press_latency", lat, 40);
    checkOutput("reset_press_all", press, 4'hF);
    applyStimulus(4'h0, 80);

    // Clean press on ch0.
    runCount(4'h1, 300, 0, np, nr, nl, nrp, nlvl, fp);
    checkOutput("ch0_press_count", np, 1);
    checkOutput("ch0_press_within_43", (fp >= 1 && fp <= 43), 1);
    checkOutput("ch0_long_count", nl, 1);
    runCount(4'h0, 80, 0, np, nr, nl, nrp, nlvl, fp);
    checkOutput("ch0_release_count", nr, 1);

    // Bounce on ch1 must never qualify.
    np = 0; nlvl = 0;
    for (int s = 0; s < 14; s++) begin
      int a, b, c, d, e, f;
      runCount((s % 2 == 0) ? 4'h2 : 4'h0, 15, 1, a, b, c, d, e, f);
      np += a;
      nlvl += e;
    end
    checkOutput("ch1_bounce_press", np, 0);
    checkOutput("ch1_bounce_level", nlvl, 0);
    applyStimulus(4'h0, 80);

    // Release glitch on ch2 while held.
    runCount(4'h4, 100, 2, np, nr, nl, nrp, nlvl, fp);
    checkOutput("ch2_press", np, 1);
    runCount(4'h0, 25, 2, np, nr, nl, nrp, nlvl, fp);
    checkOutput("ch2_glitch_release", nr, 0);
    checkOutput("ch2_glitch_level", nlvl, 25);
    runCount(4'h4, 300, 2, np, nr, nl, nrp, nlvl, fp);
    checkOutput("ch2_long_after_glitch", nl, 1);
    checkOutput("ch2_no_repress", np, 0);
    applyStimulus(4'h0, 80);

    // Two channels rising together press together.
    pb  = 4'hC;
    lat = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk_in);
      if (press != '0) begin
        lat = k;
        break;
      end
    end
    checkOutput("simul_press", press, 4'hC);
    applyStimulus(4'hC, 20);
    applyStimulus(4'h0, 80);

    // Long hold on ch0: one long press, repeats only with the feature built in.
    runCount(4'h1, 415, 0, np, nr, nl, nrp, nlvl, fp);
    checkOutput("rpt_long_count", nl, 1);
`ifdef BUTTON_COND_REPEAT_EN
    checkOutput("rpt_repeat_count", nrp, 4);
`else
    checkOutput("rpt_repeat_count", nrp, 0);
`endif
    applyStimulus(4'h0, 80);

    // Randomized traffic with a reset in the middle; the scoreboard checks it all.
    for (int s = 0; s < 60; s++) begin
      if (s == 30) begin
        rst = 1'b1;
        applyStimulus(4'($urandom_range(0, 15)), 2);
        rst = 1'b0;
      end
      applyStimulus(4'($urandom_range(0, 15)), $urandom_range(1, 60));
    end
    applyStimulus(4'h0, 100);
    checkOutput("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
